// File: rtl/spike_encoder_pkg.sv
// Shared types and defaults for the pixel-to-spike encoder: coding modes,
// FSM state encoding and the default 16-bit LFSR tap mask.
package spike_encoder_pkg;

   localparam int INPUT_SIZE   = 4;
   localparam int PIXEL_BITS   = 8;
   localparam int SPIKE_WINDOW = 16;

   // Taps for x^16+x^14+x^13+x^11+1 on a shift-left Fibonacci register
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

   typedef enum logic [1:0] {
      ENC_RATE    = 2'd0,
      ENC_STOCH   = 2'd1,
      ENC_LATENCY = 2'd2,
      ENC_RSVD    = 2'd3
   } encode_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } enc_state_e;

endpackage

// File: rtl/spike_encoder_lfsr_gen.sv
// Fibonacci LFSR for stochastic coding. o_value is the value the current
// step must use: the (zero-safe) seed on load, else the advanced state.
module lfsr_gen
   import spike_encoder_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_16)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_seed,
   input  logic             i_advance,
   output logic [WIDTH-1:0] o_value
);

   logic [WIDTH-1:0] r_lfsr;
   logic [WIDTH-1:0] w_seed_eff;
   logic [WIDTH-1:0] w_stepped;

   // An all-zero state would lock the register, so seed 0 maps to 1
   assign w_seed_eff = (i_seed == '0) ? WIDTH'(1) : i_seed;
   assign w_stepped  = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
   assign o_value    = i_load ? w_seed_eff : w_stepped;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= WIDTH'(1);
      end else if (i_load || i_advance) begin
         r_lfsr <= o_value;
      end
   end

endmodule

// File: rtl/spike_encoder.sv
// Multi-channel pixel-to-spike encoder: one frame in, WINDOW spike vectors out
// using rate, stochastic or latency coding. Both sides use valid/ready;
// a transfer happens on a rising edge where valid and ready are both high.
module spike_encoder
   import spike_encoder_pkg::*;
#(
   parameter  int NUM_CH      = INPUT_SIZE,
   parameter  int PIXEL_WIDTH = PIXEL_BITS,
   parameter  int WINDOW      = SPIKE_WINDOW,
   parameter  int LFSR_WIDTH  = 16,
   localparam int STEP_W      = $clog2(WINDOW)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load_valid,
   output logic                          load_ready,
   input  logic [NUM_CH*PIXEL_WIDTH-1:0] pixel_data,
   input  logic [1:0]                    mode,
   input  logic [LFSR_WIDTH-1:0]         seed,
   output logic                          spike_valid,
   input  logic                          spike_ready,
   output logic [NUM_CH-1:0]             spikes,
   output logic [STEP_W-1:0]             step_idx,
   output logic                          spike_last,
   output enc_state_e                    o_dbg_state
);

   localparam int LAT_SH = PIXEL_WIDTH - STEP_W;

   enc_state_e       r_state, w_state_nxt;
   encode_mode_e     r_mode, w_tgt_mode;
   logic [STEP_W-1:0] r_step, w_tgt_step;
   logic [NUM_CH-1:0] r_spikes, w_spk;
   logic [LFSR_WIDTH-1:0] w_lfsr;
   logic w_load, w_adv, w_last_hs;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      load_ready  = 1'b0;
      spike_valid = 1'b0;
      w_load      = 1'b0;
      w_adv       = 1'b0;
      w_last_hs   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            spike_valid = 1'b1;
            if (spike_ready) begin
               if (r_step == STEP_W'(WINDOW - 1)) begin
                  w_last_hs   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_adv = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Spikes are always computed for the step about to be registered
   assign w_tgt_step = w_load ? '0 : r_step + STEP_W'(1);
   assign w_tgt_mode = w_load ? encode_mode_e'(mode) : r_mode;

   lfsr_gen #(.WIDTH(LFSR_WIDTH)) u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_seed    (seed),
      .i_advance (w_adv),
      .o_value   (w_lfsr)
   );

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam int ROT = (3 * c) % LFSR_WIDTH;
      logic [PIXEL_WIDTH-1:0] r_pix, r_acc, w_pix, w_acc_base, w_rot;
      logic [PIXEL_WIDTH:0]   w_sum;
      logic [STEP_W-1:0]      w_lat_t;
      logic                   w_bit;

      assign w_pix      = w_load ? pixel_data[c*PIXEL_WIDTH +: PIXEL_WIDTH] : r_pix;
      assign w_acc_base = w_load ? '0 : r_acc;
      assign w_sum      = {1'b0, w_acc_base} + {1'b0, w_pix};
      assign w_rot      = PIXEL_WIDTH'({w_lfsr, w_lfsr} >> ROT);
      // ~pixel is (2^PIXEL_WIDTH-1-pixel): brighter pixels fire earlier
      assign w_lat_t    = STEP_W'(~w_pix >> LAT_SH);

      always_comb begin
         w_bit = 1'b0;
         case (w_tgt_mode)
            ENC_RATE:    w_bit = w_sum[PIXEL_WIDTH];
            ENC_STOCH:   w_bit = (w_pix > w_rot);
            ENC_LATENCY: w_bit = (w_pix != '0) && (w_lat_t == w_tgt_step);
            default:     w_bit = 1'b0;
         endcase
      end

      assign w_spk[c] = w_bit;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_pix <= '0;
            r_acc <= '0;
         end else begin
            if (w_load)          r_pix <= w_pix;
            if (w_load || w_adv) r_acc <= w_sum[PIXEL_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_step   <= '0;
         r_spikes <= '0;
         r_mode   <= ENC_RATE;
      end else if (w_load || w_adv) begin
         r_step   <= w_tgt_step;
         r_spikes <= w_spk;
         r_mode   <= w_tgt_mode;
      end else if (w_last_hs) begin
         r_step   <= '0;
         r_spikes <= '0;
      end
   end

   assign spikes      = r_spikes;
   assign step_idx    = r_step;
   assign spike_last  = (r_state == ST_RUN) && (r_step == STEP_W'(WINDOW - 1));
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: a reference model fills an expected
// queue on every accepted frame; a negedge monitor pops it per spike transfer.
module tb_spike_encoder;
   import spike_encoder_pkg::*;

   localparam int NCH = 4;
   localparam int PW  = 8;
   localparam int WIN = 16;
   localparam int SW  = 4;
   localparam int EW  = NCH + SW + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load_valid;
   logic              load_ready;
   logic [NCH*PW-1:0] pixel_data;
   logic [1:0]        mode;
   logic [15:0]       seed;
   logic              spike_valid;
   logic              spike_ready;
   logic [NCH-1:0]    spikes;
   logic [SW-1:0]     step_idx;
   logic              spike_last;
   enc_state_e        dbg_state;

   spike_encoder #(
      .NUM_CH(NCH), .PIXEL_WIDTH(PW), .WINDOW(WIN), .LFSR_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .pixel_data(pixel_data), .mode(mode), .seed(seed),
      .spike_valid(spike_valid), .spike_ready(spike_ready),
      .spikes(spikes), .step_idx(step_idx), .spike_last(spike_last),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [EW-1:0] exp_q[$];
   int cnt[NCH];
   int first_step[NCH];
   int lasts;
   int odd_viol;
   logic [NCH-1:0] seq[WIN];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      logic [EW-1:0] e;
      if (!rst && spike_valid && spike_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_vector: got spikes=%b step=%0d, required no transfer", spikes, step_idx);
         end else begin
            e = exp_q.pop_front();
            if ({spikes, step_idx, spike_last} !== e) begin
               errors++;
               $display("FAIL vector: got spikes=%b step=%0d last=%b, required spikes=%b step=%0d last=%b",
                        spikes, step_idx, spike_last, e[EW-1 -: NCH], e[SW:1], e[0]);
            end
         end
         for (int c = 0; c < NCH; c++) begin
            if (spikes[c]) begin
               cnt[c]++;
               if (first_step[c] < 0) first_step[c] = int'(step_idx);
            end
         end
         if (spike_last) lasts++;
         if (spikes[1] && !step_idx[0]) odd_viol++;
         seq[step_idx] = spikes;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic clear_stats();
      for (int c = 0; c < NCH; c++) begin
         cnt[c] = 0;
         first_step[c] = -1;
      end
      lasts = 0;
      odd_viol = 0;
   endtask

   task automatic push_frame(input logic [NCH*PW-1:0] pix, input logic [1:0] md, input logic [15:0] sd);
      logic [15:0]    s;
      logic [31:0]    dbl;
      logic [NCH-1:0] sp;
      int             p;
      s = (sd == 16'd0) ? 16'd1 : sd;
      for (int k = 0; k < WIN; k++) begin
         sp = '0;
         for (int c = 0; c < NCH; c++) begin
            p = int'(pix[c*PW +: PW]);
            case (md)
               2'd0: sp[c] = ((((k + 1) * p) / 256) > ((k * p) / 256));
               2'd1: begin
                  dbl = {s, s} >> (3 * c);
                  sp[c] = (p > int'(dbl[7:0]));
               end
               2'd2: sp[c] = (p != 0) && (((255 - p) >> 4) == k);
               default: sp[c] = 1'b0;
            endcase
         end
         exp_q.push_back({sp, 4'(k), (k == WIN - 1)});
         s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      end
   endtask

   task automatic do_load(input logic [NCH*PW-1:0] pix, input logic [1:0] md, input logic [15:0] sd);
      for (int i = 0; i < 100 && !load_ready; i++) @(posedge clk) #1;
      checks++;
      if (!load_ready) begin
         errors++;
         $display("FAIL load_wait: load_ready=%b, required 1 within 100 cycles", load_ready);
      end
      load_valid = 1'b1;
      pixel_data = pix;
      mode = md;
      seed = sd;
      push_frame(pix, md, sd);
      @(posedge clk) #1;
      load_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 600 && !(load_ready && exp_q.size() == 0); i++) @(posedge clk) #1;
      checks++;
      if (!(load_ready && exp_q.size() == 0)) begin
         errors++;
         $display("FAIL frame_done: load_ready=%b pending=%0d, required 1 and 0", load_ready, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({load_ready, spike_valid, spikes, step_idx, spike_last} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b val=%b spk=%b step=%0d last=%b, required 1 0 0000 0 0",
                  load_ready, spike_valid, spikes, step_idx, spike_last);
      end
      checks++;
      if (dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
      end
      rst = 1'b0;
      @(posedge clk) #1;
      checks++;
      if (load_ready !== 1'b1 || spike_valid !== 1'b0) begin
         errors++;
         $display("FAIL after_reset: got rdy=%b val=%b, required 1 0", load_ready, spike_valid);
      end
   endtask

   task automatic test_rate();
      int req[NCH];
      req = '{0, 8, 15, 1};
      clear_stats();
      spike_ready = 1'b1;
      do_load({8'd16, 8'd255, 8'd128, 8'd0}, 2'd0, 16'd0);
      checks++;
      if (spike_valid !== 1'b1 || step_idx !== 4'd0 || load_ready !== 1'b0) begin
         errors++;
         $display("FAIL rate_first: got val=%b step=%0d rdy=%b, required 1 0 0", spike_valid, step_idx, load_ready);
      end
      wait_done();
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (cnt[c] !== req[c]) begin
            errors++;
            $display("FAIL rate_count ch%0d: got %0d, required %0d", c, cnt[c], req[c]);
         end
      end
      checks++;
      if (odd_viol !== 0) begin
         errors++;
         $display("FAIL rate_ch1_odd: got %0d even-step spikes, required 0", odd_viol);
      end
      checks++;
      if (lasts !== 1) begin
         errors++;
         $display("FAIL rate_last: got %0d, required 1", lasts);
      end
   endtask

   task automatic test_latency();
      int req[NCH];
      req = '{0, 7, 15, -1};
      clear_stats();
      do_load({8'd0, 8'd1, 8'd128, 8'd255}, 2'd2, 16'd0);
      wait_done();
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (first_step[c] !== req[c] || cnt[c] !== ((c == 3) ? 0 : 1)) begin
            errors++;
            $display("FAIL latency ch%0d: got step=%0d count=%0d, required step=%0d count=%0d",
                     c, first_step[c], cnt[c], req[c], (c == 3) ? 0 : 1);
         end
      end
   endtask

   task automatic test_stoch();
      logic [NCH-1:0] a[WIN];
      clear_stats();
      do_load({4{8'hFF}}, 2'd1, 16'hACE1);
      wait_done();
      a = seq;
      clear_stats();
      do_load({4{8'h00}}, 2'd1, 16'hACE1);
      wait_done();
      checks++;
      if (cnt[0] + cnt[1] + cnt[2] + cnt[3] !== 0) begin
         errors++;
         $display("FAIL stoch_zero: got %0d spikes, required 0", cnt[0] + cnt[1] + cnt[2] + cnt[3]);
      end
      do_load({4{8'hFF}}, 2'd1, 16'hACE1);
      wait_done();
      for (int k = 0; k < WIN; k++) begin
         checks++;
         if (seq[k] !== a[k]) begin
            errors++;
            $display("FAIL stoch_repeat step%0d: got %b, required %b", k, seq[k], a[k]);
         end
      end
      do_load({4{8'hFF}}, 2'd1, 16'd0);
      wait_done();
      a = seq;
      do_load({4{8'hFF}}, 2'd1, 16'd1);
      wait_done();
      checks++;
      if (seq !== a) begin
         errors++;
         $display("FAIL stoch_seed0: seed 0 sequence differs from seed 1, required identical");
      end
   endtask

   task automatic test_stall();
      logic [NCH*PW-1:0] pix;
      logic [NCH-1:0]    pv_spk;
      logic [SW-1:0]     pv_step;
      logic              pv_val, pv_rdy;
      pix = {8'd255, 8'd33, 8'd77, 8'd200};
      clear_stats();
      spike_ready = 1'b0;
      do_load(pix, 2'd0, 16'd0);
      for (int i = 0; i < 400 && !(load_ready && exp_q.size() == 0); i++) begin
         spike_ready = 1'($urandom_range(0, 1));
         load_valid  = (step_idx != 4'(WIN - 1));
         pixel_data  = 32'hDEADBEEF;
         mode        = 2'd2;
         if (spike_valid) begin
            checks++;
            if (load_ready !== 1'b0) begin
               errors++;
               $display("FAIL run_load_ready: got %b, required 0", load_ready);
            end
         end
         pv_spk = spikes; pv_step = step_idx; pv_val = spike_valid; pv_rdy = spike_ready;
         @(posedge clk) #1;
         if (pv_val && !pv_rdy) begin
            checks++;
            if (spikes !== pv_spk || step_idx !== pv_step || spike_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold: got spk=%b step=%0d val=%b, required spk=%b step=%0d val=1",
                        spikes, step_idx, spike_valid, pv_spk, pv_step);
            end
         end
      end
      load_valid = 1'b0;
      spike_ready = 1'b1;
      mode = 2'd0;
      wait_done();
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (cnt[c] !== (int'(pix[c*PW +: PW]) * WIN) / 256) begin
            errors++;
            $display("FAIL stall_count ch%0d: got %0d, required %0d", c, cnt[c], (int'(pix[c*PW +: PW]) * WIN) / 256);
         end
      end
   endtask

   task automatic test_rst_mid();
      int req[NCH];
      req = '{8, 15, 1, 0};
      spike_ready = 1'b1;
      do_load({8'd0, 8'd16, 8'd255, 8'd128}, 2'd0, 16'd0);
      for (int i = 0; i < 40 && step_idx != 4'd5; i++) @(posedge clk) #1;
      checks++;
      if (step_idx !== 4'd5) begin
         errors++;
         $display("FAIL rst_reach: got step=%0d, required 5", step_idx);
      end
      rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      exp_q.delete();
      checks++;
      if ({spike_valid, load_ready, spike_last, step_idx, spikes} !== {1'b0, 1'b1, 1'b0, 4'd0, 4'd0}) begin
         errors++;
         $display("FAIL rst_mid: got val=%b rdy=%b last=%b step=%0d spk=%b, required 0 1 0 0 0000",
                  spike_valid, load_ready, spike_last, step_idx, spikes);
      end
      clear_stats();
      do_load({8'd0, 8'd16, 8'd255, 8'd128}, 2'd0, 16'd0);
      wait_done();
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (cnt[c] !== req[c]) begin
            errors++;
            $display("FAIL rst_next_count ch%0d: got %0d, required %0d", c, cnt[c], req[c]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc_cyc[3];
      int n;
      logic accepted;
      logic [NCH*PW-1:0] pix;
      pix = {8'd255, 8'd128, 8'd32, 8'd64};
      n = 0;
      clear_stats();
      spike_ready = 1'b1;
      mode = 2'd0;
      seed = 16'd0;
      pixel_data = pix;
      load_valid = 1'b1;
      for (int i = 0; i < 200 && n < 3; i++) begin
         @(negedge clk);
         accepted = load_valid && load_ready;
         if (accepted) begin
            push_frame(pixel_data, mode, seed);
            acc_cyc[n] = cyc;
         end
         @(posedge clk) #1;
         if (accepted) begin
            n++;
            if (n == 2) mode = 2'd3;
            if (n == 3) load_valid = 1'b0;
         end
      end
      load_valid = 1'b0;
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL b2b_accepts: got %0d, required 3", n);
      end else begin
         for (int f = 1; f < 3; f++) begin
            checks++;
            if (acc_cyc[f] - acc_cyc[f-1] !== WIN + 1) begin
               errors++;
               $display("FAIL b2b_period%0d: got %0d, required %0d", f, acc_cyc[f] - acc_cyc[f-1], WIN + 1);
            end
         end
      end
      wait_done();
      checks++;
      if (lasts !== 3) begin
         errors++;
         $display("FAIL b2b_last: got %0d, required 3", lasts);
      end
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (cnt[c] !== 2 * ((int'(pix[c*PW +: PW]) * WIN) / 256)) begin
            errors++;
            $display("FAIL b2b_count ch%0d: got %0d, required %0d", c, cnt[c], 2 * ((int'(pix[c*PW +: PW]) * WIN) / 256));
         end
      end
   endtask

   initial begin
      load_valid  = 1'b0;
      pixel_data  = '0;
      mode        = 2'd0;
      seed        = 16'd0;
      spike_ready = 1'b1;
      clear_stats();
      test_reset();
      test_rate();
      test_latency();
      test_stoch();
      test_stall();
      test_rst_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spike_encoder.md
# spike_encoder

Parametrised multi-channel pixel-to-spike encoder: accepts one frame of NUM_CH pixels per handshake and emits WINDOW timesteps of spike vectors, one vector per output handshake. It sits between the pixel source and the first hidden layer, replacing the fixed rate-coder with run-time-selectable deterministic-rate, stochastic (LFSR) and latency coding.

## Interface
Parameters:
- NUM_CH, 4: pixel channels per frame (matches INPUT_SIZE).
- PIXEL_WIDTH, 8: bits per pixel, unsigned.
- WINDOW, 16: timesteps per frame; power of two, 2 ≤ WINDOW ≤ 2^PIXEL_WIDTH.
- LFSR_WIDTH, 16: stochastic generator width; must be ≥ PIXEL_WIDTH.

Ports:
- clk  in  1  rising-edge clock; the block uses this single clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  frame present on pixel_data.
- load_ready  out  1  encoder idle, frame may be accepted.
- pixel_data  in  NUM_CH*PIXEL_WIDTH  channel c at bits [c*PIXEL_WIDTH +: PIXEL_WIDTH].
- mode  in  2  0 = rate, 1 = stochastic, 2 = latency, 3 = reserved; sampled on load.
- seed  in  LFSR_WIDTH  LFSR seed; sampled on load.
- spike_valid  out  1  spike vector for step_idx valid.
- spike_ready  in  1  consumer accepts current vector.
- spikes  out  NUM_CH  one bit per channel for this timestep.
- step_idx  out  $clog2(WINDOW)  current timestep, 0..WINDOW-1.
- spike_last  out  1  high with spike_valid on step WINDOW-1.

## Operation
- FSM states IDLE, RUN. Reset → IDLE.
- IDLE: load_ready = 1. On load_valid && load_ready: latch pixels, mode, seed (seed 0 replaced by 1); clear per-channel accumulators; step = 0; compute step-0 spikes; → RUN.
- RUN: spike_valid = 1, load_ready = 0. On spike_valid && spike_ready: if step == WINDOW-1 → IDLE; else step++, compute next spikes, advance LFSR once. No handshake: all outputs and internal state hold (stall).
- Mode 0 (rate): per channel accumulator acc (PIXEL_WIDTH bits). At each step sum = acc + pixel (PIXEL_WIDTH+1 bits); spike = sum[PIXEL_WIDTH]; acc = sum[PIXEL_WIDTH-1:0]. Spikes per frame = floor(pixel*WINDOW / 2^PIXEL_WIDTH).
- Mode 1 (stochastic): Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1 at default width. Channel c random value r_c = low PIXEL_WIDTH bits of LFSR rotated right by 3*c. spike = (pixel > r_c). Pixel 0 never spikes.
- Mode 2 (latency): exactly one spike at step t = (2^PIXEL_WIDTH-1-pixel) >> (PIXEL_WIDTH - log2(WINDOW)); pixel 0 never spikes.
- Mode 3: window runs normally, spikes all zero.
- load_valid while in RUN ignored (load_ready = 0); frame stays with source.

## Timing
- Reset values: load_ready = 1 (first cycle after reset deasserts), spike_valid = 0, spikes = 0, step_idx = 0, spike_last = 0; LFSR = 1, accumulators = 0.
- Load accepted at edge n → spike_valid = 1 with step_idx = 0 from cycle n+1. Spikes registered; no combinational path from pixel_data or spike_ready to spikes.
- Full-throughput frame (spike_ready tied 1): WINDOW cycles RUN, then 1 cycle IDLE before next load accept; frame period WINDOW+1.
- Final handshake at edge m → load_ready = 1 and spike_valid = 0 from cycle m+1.
- rst mid-RUN: aborts frame, all outputs to reset values next cycle; no partial spike_last.

## Structure
- Add to network_pkg: encode_mode_e enum (ENC_RATE, ENC_STOCH, ENC_LATENCY, ENC_RSVD), default LFSR tap mask constant, default NUM_CH/PIXEL_WIDTH/WINDOW taken from existing INPUT_SIZE/PIXEL_WIDTH/SPIKE_WINDOW.
- Sub-module lfsr_gen (load, seed, advance, value); per-channel encoding logic in a generate loop inside spike_encoder.

## Test plan
- Reset, then rate mode, pixels {0,128,255,16}, spike_ready = 1 → spike counts {0,8,15,1}; ch1 spikes on odd step_idx only; spike_last on step 15.
- Latency mode, pixels {255,128,1,0} → single spikes at steps 0, 7, 15; ch3 none.
- Stochastic mode, seed 0xACE1, pixel 255 all channels → spike every step except where r_c = 255 (match reference model); pixel 0 → zero spikes; same seed reloaded → identical sequence; seed 0 behaves as seed 1.
- Random spike_ready stalls in rate mode → spikes/step_idx hold during stall; totals identical to unstalled run; load_valid during RUN not accepted.
- Assert rst at step 5 → next cycle spike_valid = 0, load_ready = 1; next frame starts at step 0 with cleared accumulators.
- Back-to-back frames with load_valid held high → frame period exactly WINDOW+1 cycles; mode 3 frame gives all-zero spikes with correct step_idx/spike_last.
